// File: rtl/red_pitaya_dac_preemph.sv
// DAC output conditioning: first-difference pre-emphasis, gain/offset, an
// enable-driven envelope ramp and 14-bit clipping with a saturation counter.
module red_pitaya_dac_preemph #(
    parameter int DW = 14
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rstn_i,
    input  logic signed [DW-1:0] dac_dat_i,
    output logic signed [13:0]   dac_dat_o,
    input  logic                 cfg_en_i,
    input  logic signed [17:0]   cfg_bb_i,
    input  logic signed [17:0]   cfg_kk_i,
    input  logic signed [13:0]   cfg_os_i,
    input  logic        [16:0]   cfg_step_i,
    input  logic                 cfg_clr_i,
    output logic                 sat_o,
    output logic        [15:0]   sat_cnt_o,
    output logic        [1:0]    state_o
);

    localparam int DIFF_W = DW + 1;
    localparam int PB_W   = DW + 4;
    localparam int GC_W   = DW + 7;
    localparam int PB_P   = DIFF_W + 18;
    localparam int PC_P   = PB_W + 18;
    localparam int PD_P   = GC_W + 18;

    localparam logic [16:0] ENV_FULL = 17'd65536;
    localparam logic signed [PD_P-1:0] C_MAX = PD_P'(8191);
    localparam logic signed [PD_P-1:0] C_MIN = PD_P'(-8192);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_ON      = 2'd2,
        ST_RAMP_DN = 2'd3
    } state_t;

    logic signed [DW-1:0]   r_xa;
    logic signed [DW-1:0]   r_xd;
    logic signed [PB_W-1:0] r_pb;
    logic signed [GC_W-1:0] r_gc;
    logic signed [13:0]     r_dat;
    logic                   r_sat;
    logic        [15:0]     r_sat_cnt;
    logic        [16:0]     r_env;
    state_t                 r_state;

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [PB_P-1:0]   w_prod_b;
    logic signed [PB_P-1:0]   w_pb_full;
    logic signed [PC_P-1:0]   w_prod_c;
    logic signed [PC_P-1:0]   w_gc_full;
    logic signed [PD_P-1:0]   w_prod_d;
    logic signed [PD_P-1:0]   w_scaled;
    logic signed [13:0]       w_dat;
    logic                     w_sat;
    logic        [17:0]       w_up;
    logic        [16:0]       w_env_up;
    logic        [16:0]       w_env_dn;
    logic        [16:0]       w_env_next;
    state_t                   w_state_next;

    // Operands are sign-extended to the full product width so every
    // multiply is exact; the pipeline registers keep only the bits that can
    // be nonzero for in-range coefficients.
    assign w_diff    = $signed({r_xa[DW-1], r_xa}) - $signed({r_xd[DW-1], r_xd});
    assign w_prod_b  = $signed({{18{w_diff[DIFF_W-1]}}, w_diff})
                     * $signed({{DIFF_W{cfg_bb_i[17]}}, cfg_bb_i});
    assign w_pb_full = $signed({{(PB_P-DW){r_xa[DW-1]}}, r_xa}) + (w_prod_b >>> 16);

    assign w_prod_c  = $signed({{18{r_pb[PB_W-1]}}, r_pb})
                     * $signed({{PB_W{cfg_kk_i[17]}}, cfg_kk_i});
    assign w_gc_full = (w_prod_c >>> 16) + $signed({{(PC_P-14){cfg_os_i[13]}}, cfg_os_i});

    // env is unsigned, so it enters the signed multiply with a zero sign bit.
    assign w_prod_d  = $signed({{18{r_gc[GC_W-1]}}, r_gc})
                     * $signed({{GC_W{1'b0}}, 1'b0, r_env});
    assign w_scaled  = w_prod_d >>> 16;

    always_comb begin
        w_dat = 14'(w_scaled);
        w_sat = 1'b0;
        if (w_scaled > C_MAX) begin
            w_dat = 14'sh1FFF;
            w_sat = 1'b1;
        end else if (w_scaled < C_MIN) begin
            w_dat = 14'sh2000;
            w_sat = 1'b1;
        end
    end

    assign w_up     = {1'b0, r_env} + {1'b0, cfg_step_i};
    assign w_env_up = (w_up >= 18'd65536) ? ENV_FULL : w_up[16:0];
    assign w_env_dn = (cfg_step_i >= r_env) ? 17'd0 : r_env - cfg_step_i;

    // A zero step leaves env where it is, so the ramp states simply hold.
    always_comb begin
        w_state_next = r_state;
        w_env_next   = r_env;
        case (r_state)
            ST_IDLE: begin
                w_env_next = 17'd0;
                if (cfg_en_i) begin
                    w_env_next   = w_env_up;
                    w_state_next = (w_env_up == ENV_FULL) ? ST_ON : ST_RAMP_UP;
                end
            end
            ST_ON: begin
                w_env_next = ENV_FULL;
                if (!cfg_en_i) begin
                    w_env_next   = w_env_dn;
                    w_state_next = (w_env_dn == 17'd0) ? ST_IDLE : ST_RAMP_DN;
                end
            end
            default: begin
                if (cfg_en_i) begin
                    w_env_next   = w_env_up;
                    w_state_next = (w_env_up == ENV_FULL) ? ST_ON : ST_RAMP_UP;
                end else begin
                    w_env_next   = w_env_dn;
                    w_state_next = (w_env_dn == 17'd0) ? ST_IDLE : ST_RAMP_DN;
                end
            end
        endcase
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            r_state <= ST_IDLE;
            r_env   <= 17'd0;
        end else begin
            r_state <= w_state_next;
            r_env   <= w_env_next;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            r_xa      <= '0;
            r_xd      <= '0;
            r_pb      <= '0;
            r_gc      <= '0;
            r_dat     <= '0;
            r_sat     <= 1'b0;
            r_sat_cnt <= 16'd0;
        end else begin
            r_xa  <= dac_dat_i;
            r_xd  <= r_xa;
            r_pb  <= PB_W'(w_pb_full);
            r_gc  <= GC_W'(w_gc_full);
            r_dat <= w_dat;
            r_sat <= w_sat;
            // The counter moves together with sat_o; a clear overrides it.
            if (cfg_clr_i) begin
                r_sat_cnt <= 16'd0;
            end else if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign dac_dat_o = r_dat;
    assign sat_o     = r_sat;
    assign sat_cnt_o = r_sat_cnt;
    assign state_o   = r_state;

endmodule

// File: tb/tb_red_pitaya_dac_preemph.sv
// Scoreboard bench for red_pitaya_dac_preemph: the driver queues hand-computed
// expectations per clock, a monitor pops and compares after each rising edge.
module tb_red_pitaya_dac_preemph;

    logic               clk;
    logic               rst_n;
    logic signed [13:0] dac_dat_i;
    logic signed [13:0] dac_dat_o;
    logic               cfg_en_i;
    logic signed [17:0] cfg_bb_i;
    logic signed [17:0] cfg_kk_i;
    logic signed [13:0] cfg_os_i;
    logic        [16:0] cfg_step_i;
    logic               cfg_clr_i;
    logic               sat_o;
    logic        [15:0] sat_cnt_o;
    logic        [1:0]  state_o;

    typedef struct {
        int idx;
        int dat;
        int sat;
        int cnt;
        int st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   txn_n = 0;

    red_pitaya_dac_preemph #(.DW(14)) dut (
        .dac_clk_i  (clk),
        .dac_rstn_i (rst_n),
        .dac_dat_i  (dac_dat_i),
        .dac_dat_o  (dac_dat_o),
        .cfg_en_i   (cfg_en_i),
        .cfg_bb_i   (cfg_bb_i),
        .cfg_kk_i   (cfg_kk_i),
        .cfg_os_i   (cfg_os_i),
        .cfg_step_i (cfg_step_i),
        .cfg_clr_i  (cfg_clr_i),
        .sat_o      (sat_o),
        .sat_cnt_o  (sat_cnt_o),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s txn=%0d got=%0d want=%0d", name, idx, act, req);
        end
    endtask

    // Drive one sample (called at a falling edge) and queue what the outputs
    // must show just after the following rising edge.
    task automatic cyc(input int x, input logic en, input logic clr,
                       input int dat, input int sat, input int cnt, input int st);
        exp_t e;
        dac_dat_i = 14'(x);
        cfg_en_i  = en;
        cfg_clr_i = clr;
        txn_n++;
        e.idx = txn_n;
        e.dat = dat;
        e.sat = sat;
        e.cnt = cnt;
        e.st  = st;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                $display("txn %0d: dat=%0d sat=%0d cnt=%0d state=%0d (want %0d %0d %0d %0d)",
                         mon_e.idx, dac_dat_o, sat_o, sat_cnt_o, state_o,
                         mon_e.dat, mon_e.sat, mon_e.cnt, mon_e.st);
                check("dat",   mon_e.idx, int'(dac_dat_o), mon_e.dat);
                check("sat",   mon_e.idx, int'(sat_o),     mon_e.sat);
                check("cnt",   mon_e.idx, int'(sat_cnt_o), mon_e.cnt);
                check("state", mon_e.idx, int'(state_o),   mon_e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        dac_dat_i  = 14'sd1000;
        cfg_en_i   = 1'b1;
        cfg_clr_i  = 1'b0;
        cfg_bb_i   = 18'sd0;
        cfg_kk_i   = 18'sd65536;
        cfg_os_i   = 14'sd0;
        cfg_step_i = 17'd65536;
        repeat (3) @(negedge clk);
        check("rst_dat",   0, int'(dac_dat_o), 0);
        check("rst_sat",   0, int'(sat_o),     0);
        check("rst_cnt",   0, int'(sat_cnt_o), 0);
        check("rst_state", 0, int'(state_o),   0);
        rst_n = 1'b1;

        // Unity gain, instant enable.
        repeat (3) cyc(1000, 1, 0, 0,    0, 0, 2);
        repeat (3) cyc(1000, 1, 0, 1000, 0, 0, 2);

        // Pre-emphasis 0.5: step 0->1000 gives 1500 then 1000; floor on -1.
        cfg_bb_i = 18'sd32768;
        repeat (3) cyc(0, 1, 0, 1000, 0, 0, 2);
        cyc(0, 1, 0, -500, 0, 0, 2);
        repeat (3) cyc(1000, 1, 0, 0, 0, 0, 2);
        cyc(1000, 1, 0, 1500, 0, 0, 2);
        repeat (2) cyc(1000, 1, 0, 1000, 0, 0, 2);
        cyc(1001, 1, 0, 1000, 0, 0, 2);
        repeat (2) cyc(1000, 1, 0, 1000, 0, 0, 2);
        cyc(1000, 1, 0, 1001, 0, 0, 2);
        cyc(1000, 1, 0, 999,  0, 0, 2);
        cyc(1000, 1, 0, 1000, 0, 0, 2);

        // Gain 1.5: clip both rails, count, clear wins over increment.
        cfg_bb_i = 18'sd0;
        cfg_kk_i = 18'sd98304;
        cyc(6000, 1, 0, 1000, 0, 0, 2);
        cyc(6000, 1, 0, 1500, 0, 0, 2);
        cyc(6000, 1, 0, 1500, 0, 0, 2);
        cyc(6000, 1, 0, 8191, 1, 1, 2);
        cyc(6000, 1, 0, 8191, 1, 2, 2);
        cyc(6000, 1, 0, 8191, 1, 3, 2);
        cyc(-6000, 1, 0, 8191,  1, 4, 2);
        cyc(-6000, 1, 0, 8191,  1, 5, 2);
        cyc(-6000, 1, 0, 8191,  1, 6, 2);
        cyc(-6000, 1, 0, -8192, 1, 7, 2);
        cyc(-6000, 1, 1, -8192, 1, 0, 2);
        cyc(-6000, 1, 0, -8192, 1, 1, 2);

        // Envelope ramp down from ON while the pipeline flushes, then up/down.
        cfg_kk_i   = 18'sd65536;
        cfg_step_i = 17'd16384;
        cyc(4000, 0, 0, -8192, 1, 2, 3);
        cyc(4000, 0, 0, -4500, 0, 2, 3);
        cyc(4000, 0, 0, -3000, 0, 2, 3);
        cyc(4000, 0, 0, 1000,  0, 2, 0);
        cyc(4000, 0, 1, 0,     0, 0, 0);
        repeat (3) cyc(4000, 0, 0, 0, 0, 0, 0);
        cyc(4000, 1, 0, 0,    0, 0, 1);
        cyc(4000, 1, 0, 1000, 0, 0, 1);
        cyc(4000, 1, 0, 2000, 0, 0, 1);
        cyc(4000, 1, 0, 3000, 0, 0, 2);
        cyc(4000, 1, 0, 4000, 0, 0, 2);
        cyc(4000, 1, 0, 4000, 0, 0, 2);
        cyc(4000, 0, 0, 4000, 0, 0, 3);
        cyc(4000, 0, 0, 3000, 0, 0, 3);
        cyc(4000, 0, 0, 2000, 0, 0, 3);
        cyc(4000, 0, 0, 1000, 0, 0, 0);
        cyc(4000, 0, 0, 0,    0, 0, 0);

        // Partial ramps and reversals.
        cyc(4000, 1, 0, 0,    0, 0, 1);
        cyc(4000, 1, 0, 1000, 0, 0, 1);
        cyc(4000, 0, 0, 2000, 0, 0, 3);
        cyc(4000, 0, 0, 1000, 0, 0, 0);
        cyc(4000, 1, 0, 0,    0, 0, 1);
        cyc(4000, 1, 0, 1000, 0, 0, 1);
        cyc(4000, 1, 0, 2000, 0, 0, 1);
        cyc(4000, 0, 0, 3000, 0, 0, 3);
        cyc(4000, 1, 0, 2000, 0, 0, 1);
        cyc(4000, 1, 0, 3000, 0, 0, 2);
        cyc(4000, 1, 0, 4000, 0, 0, 2);

        // Zero step freezes env in RAMP_DN.
        cfg_step_i = 17'd0;
        cyc(4000, 0, 0, 4000, 0, 0, 3);
        cyc(4000, 0, 0, 4000, 0, 0, 3);
        cfg_step_i = 17'd16384;
        cyc(4000, 0, 0, 4000, 0, 0, 3);
        cyc(4000, 1, 0, 3000, 0, 0, 2);

        // Offset is scaled by env and vanishes in IDLE.
        cfg_os_i = 14'sd100;
        cyc(4000, 1, 0, 4000, 0, 0, 2);
        cyc(4000, 1, 0, 4100, 0, 0, 2);
        cyc(4000, 1, 0, 4100, 0, 0, 2);
        cyc(4000, 0, 0, 4100, 0, 0, 3);
        cyc(4000, 0, 0, 3075, 0, 0, 3);
        cyc(4000, 0, 0, 2050, 0, 0, 3);
        cyc(4000, 0, 0, 1025, 0, 0, 0);
        cyc(4000, 0, 0, 0,    0, 0, 0);
        cyc(4000, 0, 0, 0,    0, 0, 0);

        // Oversized step clamps straight to ON; offset drives saturation.
        cfg_step_i = 17'd131071;
        cfg_os_i   = 14'sd8000;
        cyc(4000, 1, 0, 0,    0, 0, 2);
        cyc(4000, 1, 0, 8191, 1, 1, 2);
        cyc(4000, 1, 0, 8191, 1, 2, 2);
        drain();

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_dat",   0, int'(dac_dat_o), 0);
        check("arst_sat",   0, int'(sat_o),     0);
        check("arst_cnt",   0, int'(sat_cnt_o), 0);
        check("arst_state", 0, int'(state_o),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After release the output stays 0 until enabled and refilled.
        cfg_step_i = 17'd65536;
        repeat (4) cyc(4000, 0, 0, 0, 0, 0, 0);
        cyc(4000, 1, 0, 0,    0, 0, 2);
        cyc(4000, 1, 0, 8191, 1, 1, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_pitaya_dac_preemph.md
RED_PITAYA_DAC_PREEMPH -- requirements
Module: red_pitaya_dac_preemph

Interface
REQ-001 SHALL have parameter DW, default 14, width of input sample.
REQ-002 SHALL have port dac_clk_i  in  1  DAC clock; the single clock, all logic on its rising edge.
REQ-003 SHALL have port dac_rstn_i  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port dac_dat_i  in  signed DW  sample stream, one sample per clock.
REQ-005 SHALL have port dac_dat_o  out  signed 14  conditioned DAC sample.
REQ-006 SHALL have port cfg_en_i  in  1  output enable; level, drives ramp FSM.
REQ-007 SHALL have port cfg_bb_i  in  signed 18  pre-emphasis coefficient, Q1.16.
REQ-008 SHALL have port cfg_kk_i  in  signed 18  gain, Q1.16 (65536 = 1.0).
REQ-009 SHALL have port cfg_os_i  in  signed 14  offset, output LSBs.
REQ-010 SHALL have port cfg_step_i  in  unsigned 17  envelope step per clock; 65536 = full scale.
REQ-011 SHALL have port cfg_clr_i  in  1  single-cycle clear of saturation counter.
REQ-012 SHALL have port sat_o  out  1  high for the clock in which dac_dat_o holds a clipped value.
REQ-013 SHALL have port sat_cnt_o  out  16  count of clipped samples, saturating at 0xFFFF.
REQ-014 SHALL have port state_o  out  2  ramp state: 0 IDLE, 1 RAMP_UP, 2 ON, 3 RAMP_DN.

Function
REQ-015 SHALL pipeline as: A: xa<=x, xd<=xa; B: pb<=xa+(((xa-xd)*bb)>>>16); C: gc<=((pb*kk)>>>16)+os; D: dac_dat_o<=sat14((gc*env)>>>16).
REQ-016 SHALL use arithmetic (floor) shifts and full-precision intermediates: diff 15-bit (DW=14), pb 18-bit, gc 21-bit; no overflow before stage D.
REQ-017 SHALL have latency 4 clocks from dac_dat_i to dac_dat_o; env applied is the env register value in the cycle stage D is registered.
REQ-018 SHALL clip stage D to [-8192, 8191] and assert sat_o in the same cycle as the clipped output.
REQ-019 SHALL increment sat_cnt_o on every sat_o cycle, holding at 0xFFFF; cfg_clr_i wins over simultaneous increment (result 0).
REQ-020 SHALL hold envelope env, unsigned 17-bit, range 0..65536.
REQ-021 IDLE: env=0; cfg_en_i=1 -> RAMP_UP with env<=min(step,65536); if that reaches 65536 go directly to ON.
REQ-022 RAMP_UP: cfg_en_i=1 -> env<=min(env+step,65536), ON when 65536 reached; cfg_en_i=0 -> RAMP_DN with env<=max(env-step,0), IDLE if 0 reached.
REQ-023 ON: env=65536; cfg_en_i=0 -> RAMP_DN with env<=max(65536-step,0), IDLE if 0.
REQ-024 RAMP_DN: cfg_en_i=0 -> env<=max(env-step,0), IDLE when 0 reached; cfg_en_i=1 -> RAMP_UP, env<=min(env+step,65536), ON if 65536.
REQ-025 cfg_step_i=0 SHALL freeze env in RAMP_UP/RAMP_DN (no state change) until step nonzero or en toggles.
REQ-026 In IDLE dac_dat_o SHALL be exactly 0 once pipeline drains (offset scaled by env=0).
REQ-027 Config inputs SHALL be sampled each cycle with no shadowing; changes affect the next sample entering their stage.

Reset
REQ-028 dac_rstn_i low SHALL asynchronously clear all pipeline registers, env, dac_dat_o, sat_o, sat_cnt_o to 0 and state_o to IDLE.
REQ-029 After release, first nonzero output SHALL require cfg_en_i=1 and pipeline refill (4 clocks).

Verification
REQ-030 bb=0, kk=65536, os=0, step=65536, en=1, x=1000 constant -> state ON after 1 clock, dac_dat_o=1000, sat_o=0.
REQ-031 bb=32768, kk=65536, ON, x steps 0->1000 held -> outputs 1500 then 1000 steady, 4-clock latency.
REQ-032 bb=0, kk=98304, ON, x=6000 -> 8191, sat_o=1, sat_cnt_o+1 per clock; x=-6000 -> -8192; cfg_clr_i pulse -> 0.
REQ-033 step=16384, x=4000, en 0->1 -> outputs 1000,2000,3000,4000 (state ON); en 1->0 -> 3000,2000,1000,0, state IDLE.
REQ-034 step=16384, en dropped after two up steps -> env 32768,16384,0, states RAMP_UP->RAMP_DN->IDLE; re-raise mid-ramp-down reverses.
REQ-035 dac_rstn_i asserted mid-ON, asynchronous to clock edge -> dac_dat_o=0, sat_cnt_o=0, state_o=IDLE immediately.
